// File: rtl/multicycle_ctrl_fsm_if.sv
// multicycle_ctrl_fsm_if: instruction fields in, datapath controls out; InstRet exists only with MC_INSTRET_EN
interface multicycle_ctrl_fsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       CondEx;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ALUOp;
    logic [3:0] State;
`ifdef MC_INSTRET_EN
    logic [31:0] InstRet;
    modport master (input Op, Funct, Rd, CondEx,
                    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, State, InstRet);
    modport slave (output Op, Funct, Rd, CondEx,
                   input PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, State, InstRet);
`else
    modport master (input Op, Funct, Rd, CondEx,
                    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, State);
    modport slave (output Op, Funct, Rd, CondEx,
                   input PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, State);
`endif
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: Moore control sequencer for the multicycle ARM datapath; MC_INSTRET_EN adds a retired-instruction counter
module multicycle_ctrl_fsm #(
    parameter int unsigned WAIT_FETCH = 0
) (
    input  logic                   clk,
    input  logic                   Reset,
    multicycle_ctrl_fsm_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        UNKNOWN = 4'd10
    } state_e;

    localparam logic [7:0] WF = 8'(WAIT_FETCH);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       last_fetch;
    logic       next_pc, reg_w, mem_w, branch, irw, adr, alua, aluop;
    logic [1:0] rs, alub;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign last_fetch = (state_q == FETCH) && (cnt_q == WF);

    always_comb begin
        state_d = FETCH;
        cnt_d   = '0;
        case (state_q)
            FETCH: begin
                state_d = last_fetch ? DECODE : FETCH;
                cnt_d   = last_fetch ? 8'd0 : cnt_q + 8'd1;
            end
            DECODE:       state_d = (bus.Op == 2'b00) ? (bus.Funct[5] ? EXECI : EXECR) :
                                    (bus.Op == 2'b01) ? MEMADR :
                                    (bus.Op == 2'b10) ? BRANCH : UNKNOWN;
            MEMADR:       state_d = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:        state_d = MEMWB;
            EXECR, EXECI: state_d = ALUWB;
            default:      state_d = FETCH;
        endcase
    end

    // UNKNOWN and the illegal codes 11-15 fall through to the all-zero defaults
    always_comb begin
        next_pc = 1'b0;
        reg_w   = 1'b0;
        mem_w   = 1'b0;
        branch  = 1'b0;
        irw     = 1'b0;
        adr     = 1'b0;
        alua    = 1'b0;
        aluop   = 1'b0;
        rs      = 2'b00;
        alub    = 2'b00;
        case (state_q)
            FETCH: begin
                alua    = 1'b1;
                alub    = 2'b10;
                rs      = 2'b10;
                irw     = last_fetch;
                next_pc = last_fetch;
            end
            DECODE: begin
                alua = 1'b1;
                alub = 2'b10;
                rs   = 2'b10;
            end
            MEMADR: alub = 2'b01;
            MEMRD:  adr = 1'b1;
            MEMWB: begin
                rs    = 2'b01;
                reg_w = 1'b1;
            end
            MEMWR: begin
                adr   = 1'b1;
                mem_w = 1'b1;
            end
            EXECR:  aluop = 1'b1;
            EXECI: begin
                alub  = 2'b01;
                aluop = 1'b1;
            end
            ALUWB:  reg_w = 1'b1;
            BRANCH: begin
                alub   = 2'b01;
                rs     = 2'b10;
                branch = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.State     = state_q;
    assign bus.IRWrite   = irw;
    assign bus.AdrSrc    = adr;
    assign bus.ALUSrcA   = alua;
    assign bus.ALUSrcB   = alub;
    assign bus.ResultSrc = rs;
    assign bus.ALUOp     = aluop;
    assign bus.RegWrite  = reg_w & bus.CondEx;
    assign bus.MemWrite  = mem_w & bus.CondEx;
    assign bus.PCWrite   = next_pc | ((((reg_w & (bus.Rd == 4'hF)) | branch)) & bus.CondEx);

`ifdef MC_INSTRET_EN
    logic [31:0] inst_ret_q;

    always_ff @(posedge clk) begin
        if (Reset)
            inst_ret_q <= '0;
        else if (state_q inside {MEMWB, MEMWR, ALUWB, BRANCH})
            inst_ret_q <= inst_ret_q + 32'd1;
    end

    assign bus.InstRet = inst_ret_q;
`endif
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Main control sequencer for the multicycle ARM datapath. Steps each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath mux selects and write enables, and gates architectural writes with the condition-check result. It sits inside the multicycle processor between the instruction register fields and the datapath; the unified instruction/data address is chosen by AdrSrc.

Parameters:
WAIT_FETCH, 0, extra FETCH cycles inserted for slow instruction memory; legal range 0..255.

Ports:
clk  input  1  system clock; all state changes on rising edge
Reset  input  1  synchronous, active-high reset
Op  input  2  Instr[27:26]
Funct  input  6  Instr[25:20]; Funct[5]=I, Funct[0]=L/S
Rd  input  4  Instr[15:12]
CondEx  input  1  condition check passed for current instruction
PCWrite  output  1  PC register enable
AdrSrc  output  1  0 = PC, 1 = ALUOut to memory address
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register enable
RegWrite  output  1  register file write enable
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  output  1  0 = RD1 register, 1 = PC
ALUSrcB  output  2  00 RD2, 01 ExtImm, 10 constant 4
ALUOp  output  1  1 = ALU decoder uses Funct; 0 = add
State  output  4  current state code, for simulation

Behaviour:
- Moore FSM, 4-bit registered state. Outputs are combinational from the state, the fetch counter, Rd and CondEx only.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, UNKNOWN=10. Codes 11-15 are illegal and go to FETCH next cycle with all outputs 0.
- Reset:
  - At the edge with Reset=1: state<=FETCH, fetch counter<=0. Reset overrides every transition, including mid-instruction; any partial instruction is abandoned with no further writes.
  - After reset, outputs show FETCH values (IRWrite=1 only if WAIT_FETCH=0).
- Transitions:
  - FETCH -> DECODE when the fetch counter equals WAIT_FETCH; otherwise stay in FETCH and increment the counter. Counter clears on leaving FETCH.
  - DECODE: Op=00,Funct[5]=0 -> EXECR; Op=00,Funct[5]=1 -> EXECI; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> UNKNOWN.
  - MEMADR -> MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD -> MEMWB. EXECR and EXECI -> ALUWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN -> FETCH.
- Internal signals per state (unlisted signals are 0):
  - FETCH: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; IRWrite=1 and NextPC=1 in the last fetch cycle only.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
  - UNKNOWN: all 0.
- Gating:
  - RegWrite = RegW & CondEx.
  - MemWrite = MemW & CondEx.
  - PCS = (RegW & Rd==4'hF) | Branch.
  - PCWrite = NextPC | (PCS & CondEx).
- Latency: with WAIT_FETCH=0, LDR=5 cycles, STR=4, data-processing=4, B=3, UNKNOWN=3. Each additional fetch wait cycle adds 1.
- IRWrite is high for exactly one cycle per instruction.

Optional Feature:
MC_INSTRET_EN:
- Defined: adds output InstRet[31:0], a retired-instruction counter.
  - Reset to 0 synchronously.
  - Increments by 1 on each clock edge leaving MEMWB, MEMWR, ALUWB or BRANCH, regardless of CondEx. UNKNOWN does not count.
  - Wraps 0xFFFFFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset asserted 2 cycles mid-EXECR, then released -> State=0 on the edge after reset; RegWrite never asserted for the aborted instruction; IRWrite=1, PCWrite=1 in the first post-reset cycle.
- LDR (Op=01, Funct=011001, Rd=3, CondEx=1) -> State sequence 0,1,2,3,4; RegWrite=1, ResultSrc=01 only in state 4; AdrSrc=1 in state 3.
- STR with CondEx=0 (Op=01, Funct=011000) -> sequence 0,1,2,5,0; MemWrite=0 throughout; PCWrite=1 only in FETCH.
- ADD reg-to-PC (Op=00, Funct=001000, Rd=15, CondEx=1) -> sequence 0,1,6,8; in state 8 RegWrite=1 and PCWrite=1. Same with CondEx=0 -> both 0.
- B (Op=10, CondEx=1), then Op=11 -> state 9 with PCWrite=1, ALUSrcB=01; next instruction visits state 10 with all outputs 0, then FETCH.
- WAIT_FETCH=2, any instruction -> FETCH lasts 3 cycles with IRWrite/PCWrite high only in the 3rd. With MC_INSTRET_EN, 3 completed instructions -> InstRet=3.
